// File: rtl/fpu_cmd_sequencer.sv
// ============================================================================
//  Module   : fpu_cmd_sequencer
//  Purpose  : Assembles 5-byte UART command frames (OPC, A, B) into a single
//             bfloat16 FPU issue and captures the FPU result.
//             Optional inter-byte / FPU-wait timeout: FPU_SEQ_TIMEOUT_EN
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fpu_cmd_sequencer #(
   parameter int OP_W           = 3,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic            clk,
   input  logic            rst_l,
   input  logic            rx_valid_i,
   input  logic [7:0]      rx_byte_i,
   output logic            fpu_start_o,
   output logic [OP_W-1:0] fpu_op_o,
   output logic [15:0]     fpu_a_o,
   output logic [15:0]     fpu_b_o,
   input  logic            fpu_done_i,
   input  logic [15:0]     fpu_result_i,
   output logic [15:0]     FPU_hp_result,
   output logic            busy_o,
   output logic [1:0]      err_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_A_HI  = 3'd1,
      S_A_LO  = 3'd2,
      S_B_HI  = 3'd3,
      S_B_LO  = 3'd4,
      S_ISSUE = 3'd5,
      S_WAIT  = 3'd6
   } state_t;

   if (OP_W < 1 || OP_W > 7 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
      $error("fpu_cmd_sequencer: OP_W must be 1..7 and TIMEOUT_CYCLES 1..65535");
   end

   state_t            r_state;
   state_t            w_next;
   logic [OP_W-1:0]   r_op;
   logic [15:0]       r_a;
   logic [15:0]       r_b;
   logic [15:0]       r_result;
   logic              r_err_opc;
   logic              w_err_to;
   logic              w_timeout;
   logic              w_opc_ok;
   logic              w_byte_state;

   assign w_opc_ok     = (rx_byte_i[7:OP_W] == '0);
   assign w_byte_state = (r_state == S_A_HI) || (r_state == S_A_LO) ||
                         (r_state == S_B_HI) || (r_state == S_B_LO);

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (rx_valid_i && w_opc_ok) w_next = S_A_HI;
         S_A_HI:  if (rx_valid_i) w_next = S_A_LO;
         S_A_LO:  if (rx_valid_i) w_next = S_B_HI;
         S_B_HI:  if (rx_valid_i) w_next = S_B_LO;
         S_B_LO:  if (rx_valid_i) w_next = S_ISSUE;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  if (fpu_done_i) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (w_timeout) w_next = S_IDLE;
   end

   // Operand/opcode registers only load in the collecting states, so they
   // stay frozen while the FPU works on them.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_op      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_result  <= '0;
         r_err_opc <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (rx_valid_i) begin
                  if (w_opc_ok) begin
                     r_op      <= rx_byte_i[OP_W-1:0];
                     r_err_opc <= 1'b0;
                  end else begin
                     r_err_opc <= 1'b1;
                  end
               end
            end
            S_A_HI:  if (rx_valid_i) r_a[15:8] <= rx_byte_i;
            S_A_LO:  if (rx_valid_i) r_a[7:0]  <= rx_byte_i;
            S_B_HI:  if (rx_valid_i) r_b[15:8] <= rx_byte_i;
            S_B_LO:  if (rx_valid_i) r_b[7:0]  <= rx_byte_i;
            S_WAIT:  if (fpu_done_i) r_result  <= fpu_result_i;
            default: ;
         endcase
      end
   end

`ifdef FPU_SEQ_TIMEOUT_EN
   localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] r_cnt;
   logic        r_err_to;
   logic        w_count_state;
   logic        w_event;

   assign w_count_state = w_byte_state || (r_state == S_WAIT);
   assign w_event       = (w_byte_state && rx_valid_i) || ((r_state == S_WAIT) && fpu_done_i);
   assign w_timeout     = w_count_state && !w_event && (r_cnt == c_TO_LAST);
   assign w_err_to      = r_err_to;

   // Bytes dropped during WAIT must not hold off the FPU-wait timeout.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_cnt    <= '0;
         r_err_to <= 1'b0;
      end else begin
         if ((w_next != r_state) || (w_byte_state && rx_valid_i)) r_cnt <= '0;
         else if (w_count_state)                                   r_cnt <= r_cnt + 16'd1;

         if (w_timeout)                                         r_err_to <= 1'b1;
         else if ((r_state == S_IDLE) && rx_valid_i && w_opc_ok) r_err_to <= 1'b0;
      end
   end
`else
   assign w_timeout = 1'b0;
   assign w_err_to  = 1'b0;
`endif

   assign fpu_start_o   = (r_state == S_ISSUE);
   assign fpu_op_o      = r_op;
   assign fpu_a_o       = r_a;
   assign fpu_b_o       = r_b;
   assign FPU_hp_result = r_result;
   assign busy_o        = (r_state != S_IDLE);
   assign err_o         = {w_err_to, r_err_opc};

endmodule

`default_nettype wire

// File: tb/tb_fpu_cmd_sequencer.sv
// ============================================================================
//  Module   : tb_fpu_cmd_sequencer
//  Purpose  : Directed scoreboard bench for fpu_cmd_sequencer (either build of
//             FPU_SEQ_TIMEOUT_EN).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fpu_cmd_sequencer;

   localparam int OP_W = 3;

   typedef struct packed {
      logic [OP_W-1:0] op;
      logic [15:0]     a;
      logic [15:0]     b;
   } cmd_t;

   logic            clk = 1'b0;
   logic            rst_l = 1'b0;
   logic            rx_valid_i = 1'b0;
   logic [7:0]      rx_byte_i = 8'h00;
   logic            fpu_start_o;
   logic [OP_W-1:0] fpu_op_o;
   logic [15:0]     fpu_a_o;
   logic [15:0]     fpu_b_o;
   logic            fpu_done_i = 1'b0;
   logic [15:0]     fpu_result_i = 16'h0000;
   logic [15:0]     FPU_hp_result;
   logic            busy_o;
   logic [1:0]      err_o;

   int   checks = 0;
   int   errors = 0;
   int   start_cnt = 0;
   cmd_t exp_q[$];
   logic [15:0] res_q[$];

   fpu_cmd_sequencer #(.OP_W(OP_W), .TIMEOUT_CYCLES(100)) dut (
      .clk          (clk),
      .rst_l        (rst_l),
      .rx_valid_i   (rx_valid_i),
      .rx_byte_i    (rx_byte_i),
      .fpu_start_o  (fpu_start_o),
      .fpu_op_o     (fpu_op_o),
      .fpu_a_o      (fpu_a_o),
      .fpu_b_o      (fpu_b_o),
      .fpu_done_i   (fpu_done_i),
      .fpu_result_i (fpu_result_i),
      .FPU_hp_result(FPU_hp_result),
      .busy_o       (busy_o),
      .err_o        (err_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (fpu_start_o === 1'b1) start_cnt <= start_cnt + 1;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid_i = 1'b1;
      rx_byte_i  = b;
      @(negedge clk);
      rx_valid_i = 1'b0;
      rx_byte_i  = 8'h00;
   endtask

   task automatic send_frame(input logic [7:0] opc, input logic [15:0] a, input logic [15:0] b);
      exp_q.push_back({opc[OP_W-1:0], a, b});
      send_byte(opc);
      send_byte(a[15:8]);
      send_byte(a[7:0]);
      send_byte(b[15:8]);
      send_byte(b[7:0]);
   endtask

   // Expects the start pulse in the cycle right after the last byte.
   task automatic expect_issue(input string tag);
      cmd_t e;
      int   n = 0;
      int   base;
      while (fpu_start_o !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " start"}, 16'(fpu_start_o), 16'h1);
      chk({tag, " latency"}, 16'(n), 16'h0);
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s scoreboard: observed=issue expected=no issue", tag);
      end else begin
         e = exp_q.pop_front();
         chk({tag, " op"}, 16'(fpu_op_o), 16'(e.op));
         chk({tag, " a"}, fpu_a_o, e.a);
         chk({tag, " b"}, fpu_b_o, e.b);
      end
      base = start_cnt;
      @(negedge clk);
      chk({tag, " start one-cycle"}, 16'(fpu_start_o), 16'h0);
      chk({tag, " busy in wait"}, 16'(busy_o), 16'h1);
      chk({tag, " single pulse"}, 16'(start_cnt - base), 16'h1);
   endtask

   task automatic finish_done(input string tag, input logic [15:0] res, input int delay);
      logic [15:0] e;
      repeat (delay) @(negedge clk);
      res_q.push_back(res);
      fpu_done_i   = 1'b1;
      fpu_result_i = res;
      @(negedge clk);
      fpu_done_i   = 1'b0;
      fpu_result_i = 16'h0000;
      e = res_q.pop_front();
      chk({tag, " result"}, FPU_hp_result, e);
      chk({tag, " busy after done"}, 16'(busy_o), 16'h0);
   endtask

   initial begin
      int base;
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst busy", 16'(busy_o), 16'h0);
      chk("rst err", 16'(err_o), 16'h0);
      chk("rst start", 16'(fpu_start_o), 16'h0);
      chk("rst result", FPU_hp_result, 16'h0000);
      chk("rst a", fpu_a_o, 16'h0000);
      rst_l = 1'b1;
      @(negedge clk);

      // Basic frame: 1.0 op 2.0 -> 3.0
      send_frame(8'h01, 16'h3F80, 16'h4000);
      expect_issue("frame1");
      chk("frame1 op held", 16'(fpu_op_o), 16'h1);
      finish_done("frame1", 16'h4040, 2);

      // Bad opcode, then recovery
      send_byte(8'hF1);
      chk("badopc err", 16'(err_o), 16'h1);
      chk("badopc busy", 16'(busy_o), 16'h0);
      send_frame(8'h02, 16'h1234, 16'h5678);
      chk("recover err cleared", 16'(err_o), 16'h0);
      expect_issue("frame2");
      finish_done("frame2", 16'hABCD, 1);

      // Done pulse outside WAIT
      fpu_done_i = 1'b1; fpu_result_i = 16'hFFFF;
      @(negedge clk);
      fpu_done_i = 1'b0; fpu_result_i = 16'h0000;
      chk("idle done ignored", FPU_hp_result, 16'hABCD);

      // Bytes during WAIT are dropped
      send_frame(8'h03, 16'h4000, 16'h3F80);
      expect_issue("frame3");
      repeat (3) send_byte(8'hAA);
      chk("drop busy", 16'(busy_o), 16'h1);
      chk("drop a", fpu_a_o, 16'h4000);
      chk("drop b", fpu_b_o, 16'h3F80);
      chk("drop op", 16'(fpu_op_o), 16'h3);
      finish_done("frame3", 16'h1234, 0);
      send_frame(8'h04, 16'h0001, 16'h0002);
      expect_issue("frame4");
      finish_done("frame4", 16'h5555, 0);

      // Reset mid-frame, then stale done
      base = start_cnt;
      send_byte(8'h05); send_byte(8'h11); send_byte(8'h22);
      chk("mid busy", 16'(busy_o), 16'h1);
      #1 rst_l = 1'b0;
      #1;
      chk("async busy", 16'(busy_o), 16'h0);
      chk("async result", FPU_hp_result, 16'h0000);
      chk("async a", fpu_a_o, 16'h0000);
      chk("async op", 16'(fpu_op_o), 16'h0);
      @(negedge clk); @(negedge clk);
      rst_l = 1'b1;
      @(negedge clk);
      fpu_done_i = 1'b1; fpu_result_i = 16'h9999;
      @(negedge clk);
      fpu_done_i = 1'b0; fpu_result_i = 16'h0000;
      chk("stale done ignored", FPU_hp_result, 16'h0000);
      chk("no start after reset", 16'(start_cnt - base), 16'h0);

      // Stalled frame
      base = start_cnt;
      send_byte(8'h01); send_byte(8'h3F);
`ifdef FPU_SEQ_TIMEOUT_EN
      repeat (99) @(negedge clk);
      chk("pre-timeout busy", 16'(busy_o), 16'h1);
      chk("pre-timeout err", 16'(err_o), 16'h0);
      @(negedge clk);
      chk("timeout busy", 16'(busy_o), 16'h0);
      chk("timeout err", 16'(err_o), 16'h2);
      chk("timeout no start", 16'(start_cnt - base), 16'h0);
      chk("timeout result kept", FPU_hp_result, 16'h0000);
      send_frame(8'h06, 16'hC000, 16'h3F00);
      chk("timeout err cleared", 16'(err_o), 16'h0);
      expect_issue("frame6");
      finish_done("frame6", 16'h4141, 1);
`else
      exp_q.push_back({3'd1, 16'h3F80, 16'h4000});
      repeat (10000) @(negedge clk);
      chk("stall busy", 16'(busy_o), 16'h1);
      chk("stall err", 16'(err_o), 16'h0);
      chk("stall no start", 16'(start_cnt - base), 16'h0);
      send_byte(8'h80); send_byte(8'h40); send_byte(8'h00);
      expect_issue("stall frame");
      finish_done("stall frame", 16'h4040, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
